fpga_card: RTL and testbench

- Card-level management block for the simulated accelerator card.
- Gives the host a simple register peek/poke path into card configuration and status: HMC, PCIe, GTY, I2C and power rails.
- Latches sticky events and raises one interrupt.
- Sits directly under the top-level bench and serves the host DPI access tasks.

---
 rtl/fpga_card_pkg.sv | 46 ++++
 rtl/fpga_card_event.sv | 48 ++++
 rtl/fpga_card.sv | 139 +++++++++++++
 tb/tb_fpga_card.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fpga_card_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpga_card_pkg
// Description : Shared constants for the card management block: register
//               addresses, fixed read values and STATUS/EVENT bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package fpga_card_pkg;

  // Register byte addresses (word aligned; address bits [1:0] are ignored)
  localparam logic [15:0] ADDR_ID        = 16'h0000;
  localparam logic [15:0] ADDR_CFG       = 16'h0004;
  localparam logic [15:0] ADDR_SCRATCH   = 16'h0008;
  localparam logic [15:0] ADDR_CTRL      = 16'h000C;
  localparam logic [15:0] ADDR_STATUS    = 16'h0010;
  localparam logic [15:0] ADDR_EVENT     = 16'h0014;
  localparam logic [15:0] ADDR_HEARTBEAT = 16'h0018;

  localparam logic [31:0] CARD_ID       = 32'hF000_1D0F;
  localparam logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

  // STATUS / EVENT layout
  localparam int STAT_HMC_LSB       = 0;
  localparam int STAT_GTY_LSB       = 8;
  localparam int STAT_PWR_LSB       = 16;
  localparam int STAT_PCIE_BIT      = 24;
  localparam int STAT_ALL_READY_BIT = 25;
  localparam int EVENT_WIDTH        = 25;

  // CTRL layout
  localparam int CTRL_HMC_LSB    = 0;
  localparam int CTRL_GTY_LSB    = 8;
  localparam int CTRL_IRQ_EN_BIT = 16;

  // Thermometer mask with the low n lanes set (n in 0..8)
  function automatic logic [7:0] lane_mask(input int n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_card_event.sv
`default_nettype none
// ============================================================================
// Module      : card_event_reg
// Description : Per-bit rising-edge detector feeding a sticky write-1-to-clear
//               event register. A new rise beats a simultaneous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module card_event_reg #(
  parameter int WIDTH = 25
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] status_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] clr_mask_i,
  output logic [WIDTH-1:0] event_o
);

  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] event_q;
  logic [WIDTH-1:0] event_d;
  logic [WIDTH-1:0] rise_w;

  // Next event state: clear requested bits first, then OR in new rises so a set wins
  always_comb begin
    rise_w  = status_i & ~status_q;
    event_d = event_q;
    if (clr_i) begin
      event_d = event_d & ~clr_mask_i;
    end
    event_d = event_d | rise_w;
  end

  // Previous-sample and sticky event registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      status_q <= '0;
      event_q  <= '0;
    end else begin
      status_q <= status_i;
      event_q  <= event_d;
    end
  end

  assign event_o = event_q;

endmodule
`default_nettype wire

// File: rtl/fpga_card.sv
`default_nettype none
// ============================================================================
// Module      : fpga_card
// Description : Card management register block. Single-cycle host peek/poke
//               into ID, config, scratch, control, live status, sticky events
//               and a heartbeat counter; drives one level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_card
  import fpga_card_pkg::*;
#(
  parameter int NUM_HMC   = 4,
  parameter int NUM_PCIE  = 1,
  parameter int NUM_GTY   = 4,
  parameter int NUM_I2C   = 2,
  parameter int NUM_POWER = 4
) (
  input  logic                 clk_main_a0,
  input  logic                 rst_main_n,
  input  logic                 req_valid,
  input  logic                 req_wr,
  input  logic [15:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  input  logic [NUM_HMC-1:0]   hmc_ready,
  input  logic [NUM_GTY-1:0]   gty_link_up,
  input  logic [NUM_POWER-1:0] power_good,
  input  logic                 pcie_link_up,
  output logic [NUM_HMC-1:0]   hmc_enable,
  output logic [NUM_GTY-1:0]   gty_enable,
  output logic                 irq
);

  localparam logic [31:0] CFG_VALUE = {12'd0, 4'(NUM_POWER), 4'(NUM_I2C),
                                       4'(NUM_GTY), 4'(NUM_PCIE), 4'(NUM_HMC)};
  // Writable CTRL bits: implemented HMC lanes, implemented GTY lanes, irq_en
  localparam logic [31:0] CTRL_MASK = {15'd0, 1'b1, lane_mask(NUM_GTY), lane_mask(NUM_HMC)};

  logic [31:0] scratch_q, scratch_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] heartbeat_q, heartbeat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        irq_q, irq_d;

  logic [15:0]            addr_w;
  logic                   wr_en_w;
  logic                   evt_clr_w;
  logic [25:0]            status_w;
  logic [EVENT_WIDTH-1:0] event_w;
  logic [31:0]            rd_mux_w;
  logic                   unused_addr_lsbs_w;

  assign addr_w             = {req_addr[15:2], 2'b00};
  assign unused_addr_lsbs_w = ^req_addr[1:0];
  assign wr_en_w            = req_valid & req_wr;
  assign evt_clr_w          = wr_en_w && (addr_w == ADDR_EVENT);

  // Assemble the live STATUS word from the card inputs
  always_comb begin
    status_w = '0;
    status_w[STAT_HMC_LSB +: NUM_HMC]   = hmc_ready;
    status_w[STAT_GTY_LSB +: NUM_GTY]   = gty_link_up;
    status_w[STAT_PWR_LSB +: NUM_POWER] = power_good;
    status_w[STAT_PCIE_BIT]             = pcie_link_up;
    status_w[STAT_ALL_READY_BIT]        = (&hmc_ready) & (&gty_link_up) &
                                          (&power_good) & pcie_link_up;
  end

  card_event_reg #(
    .WIDTH(EVENT_WIDTH)
  ) u_event (
    .clk_i      (clk_main_a0),
    .rst_n_i    (rst_main_n),
    .status_i   (status_w[EVENT_WIDTH-1:0]),
    .clr_i      (evt_clr_w),
    .clr_mask_i (req_wdata[EVENT_WIDTH-1:0]),
    .event_o    (event_w)
  );

  // Read data mux, sampled in the request cycle
  always_comb begin
    rd_mux_w = BAD_ADDR_DATA;
    case (addr_w)
      ADDR_ID:        rd_mux_w = CARD_ID;
      ADDR_CFG:       rd_mux_w = CFG_VALUE;
      ADDR_SCRATCH:   rd_mux_w = scratch_q;
      ADDR_CTRL:      rd_mux_w = ctrl_q;
      ADDR_STATUS:    rd_mux_w = {6'd0, status_w};
      ADDR_EVENT:     rd_mux_w = {{(32-EVENT_WIDTH){1'b0}}, event_w};
      ADDR_HEARTBEAT: rd_mux_w = heartbeat_q;
      default:        rd_mux_w = BAD_ADDR_DATA;
    endcase
  end

  // Next-state for writable registers, heartbeat, response and interrupt
  always_comb begin
    scratch_d   = scratch_q;
    ctrl_d      = ctrl_q;
    heartbeat_d = heartbeat_q + 32'd1;
    rsp_valid_d = req_valid;
    rsp_rdata_d = (req_valid && !req_wr) ? rd_mux_w : 32'd0;
    irq_d       = ctrl_q[CTRL_IRQ_EN_BIT] & (|event_w);
    if (wr_en_w && (addr_w == ADDR_SCRATCH)) begin
      scratch_d = req_wdata;
    end
    if (wr_en_w && (addr_w == ADDR_CTRL)) begin
      ctrl_d = req_wdata & CTRL_MASK;
    end
  end

  // Register state; reset drops any pending response immediately
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      scratch_q   <= '0;
      ctrl_q      <= '0;
      heartbeat_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      scratch_q   <= scratch_d;
      ctrl_q      <= ctrl_d;
      heartbeat_q <= heartbeat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign hmc_enable = ctrl_q[CTRL_HMC_LSB +: NUM_HMC];
  assign gty_enable = ctrl_q[CTRL_GTY_LSB +: NUM_GTY];
  assign irq        = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_fpga_card.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fpga_card
// Description : Self-checking bench for fpga_card: register vector table,
//               response scoreboard and hand-written event/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_card;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wr;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [3:0]  hmc_ready, gty_link_up, power_good;
  logic        pcie_link_up;
  logic [3:0]  hmc_enable, gty_enable;
  logic        irq;

  always #5 clk = ~clk;

  fpga_card dut (
    .clk_main_a0 (clk),
    .rst_main_n  (rst_n),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .hmc_ready   (hmc_ready),
    .gty_link_up (gty_link_up),
    .power_good  (power_good),
    .pcie_link_up(pcie_link_up),
    .hmc_enable  (hmc_enable),
    .gty_enable  (gty_enable),
    .irq         (irq)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_hmc;
    logic [3:0]  exp_gty;
  } vec_t;

  vec_t        vecs[16];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hb_model = 32'd0;   // clock edges seen since reset release
  logic [31:0] hb_a, hb_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request at a falling edge; returns at the next falling edge
  task automatic req(input logic wr, input logic [15:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    exp_q.push_back(wr ? 32'd0 : exp);
    @(negedge clk);
    req_valid = 1'b0;
    req_wr    = 1'b0;
  endtask

  // Heartbeat reference: counts rising edges while out of reset
  initial forever begin
    @(posedge clk);
    hb_model = rst_n ? hb_model + 32'd1 : 32'd0;
  end

  // Response monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%h expected no response", rsp_rdata);
      end else begin
        check("rsp_rdata", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 16'h0000, 32'h0,         32'hF000_1D0F, 4'h0, 4'h0};
    vecs[1]  = '{1'b0, 16'h0004, 32'h0,         32'h0004_2414, 4'h0, 4'h0};
    vecs[2]  = '{1'b0, 16'h0008, 32'h0,         32'h0000_0000, 4'h0, 4'h0};
    vecs[3]  = '{1'b0, 16'h000C, 32'h0,         32'h0000_0000, 4'h0, 4'h0};
    vecs[4]  = '{1'b0, 16'h0014, 32'h0,         32'h0000_0000, 4'h0, 4'h0};
    vecs[5]  = '{1'b0, 16'h0010, 32'h0,         32'h0000_0000, 4'h0, 4'h0};
    vecs[6]  = '{1'b1, 16'h0008, 32'hA5A5_1234, 32'h0,         4'h0, 4'h0};
    vecs[7]  = '{1'b0, 16'h0008, 32'h0,         32'hA5A5_1234, 4'h0, 4'h0};
    vecs[8]  = '{1'b0, 16'h0040, 32'h0,         32'hDEAD_BEEF, 4'h0, 4'h0};
    vecs[9]  = '{1'b1, 16'h0040, 32'h1234_5678, 32'h0,         4'h0, 4'h0};
    vecs[10] = '{1'b0, 16'h0008, 32'h0,         32'hA5A5_1234, 4'h0, 4'h0};
    vecs[11] = '{1'b0, 16'h000B, 32'h0,         32'hA5A5_1234, 4'h0, 4'h0};
    vecs[12] = '{1'b1, 16'h000C, 32'hFFFF_FFFF, 32'h0,         4'hF, 4'hF};
    vecs[13] = '{1'b0, 16'h000C, 32'h0,         32'h0001_0F0F, 4'hF, 4'hF};
    vecs[14] = '{1'b1, 16'h0040, 32'h0,         32'h0,         4'hF, 4'hF};
    vecs[15] = '{1'b0, 16'h000C, 32'h0,         32'h0001_0F0F, 4'hF, 4'hF};

    rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    hmc_ready = '0; gty_link_up = '0; power_good = '0; pcie_link_up = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_enables", {24'd0, hmc_enable, gty_enable}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: back-to-back register accesses with enable output checks
    for (int i = 0; i < 16; i++) begin
      req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      check("hmc_enable", {28'd0, hmc_enable}, {28'd0, vecs[i].exp_hmc});
      check("gty_enable", {28'd0, gty_enable}, {28'd0, vecs[i].exp_gty});
    end
    check("irq_no_event", {31'd0, irq}, 32'd0);

    // Rising edges latch events and raise irq
    hmc_ready = 4'b0001;
    repeat (2) @(negedge clk);
    gty_link_up = 4'b0100;
    repeat (2) @(negedge clk);
    check("irq_event", {31'd0, irq}, 32'd1);
    req(1'b0, 16'h0010, 32'h0, 32'h0000_0401);
    req(1'b0, 16'h0014, 32'h0, 32'h0000_0401);
    req(1'b1, 16'h0014, 32'h0000_0001, 32'h0);
    req(1'b0, 16'h0014, 32'h0, 32'h0000_0400);

    // New rise on bit 11 coincides with its W1C: set wins
    gty_link_up = 4'b1100;
    req(1'b1, 16'h0014, 32'h0000_0800, 32'h0);
    req(1'b0, 16'h0014, 32'h0, 32'h0000_0C00);
    req(1'b1, 16'h0014, 32'h0000_0C00, 32'h0);
    req(1'b0, 16'h0014, 32'h0, 32'h0000_0000);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // All inputs up: all_ready, pcie event, irq gated by irq_en
    req(1'b1, 16'h000C, 32'h0000_0F0F, 32'h0);
    hmc_ready = 4'hF; gty_link_up = 4'hF; power_good = 4'hF; pcie_link_up = 1'b1;
    repeat (3) @(negedge clk);
    check("irq_disabled", {31'd0, irq}, 32'd0);
    req(1'b0, 16'h0010, 32'h0, 32'h030F_0F0F);
    req(1'b0, 16'h0014, 32'h0, 32'h010F_030E);
    req(1'b1, 16'h000C, 32'h0001_0000, 32'h0);
    check("hmc_enable_off", {28'd0, hmc_enable}, 32'd0);
    @(negedge clk);
    check("irq_enabled", {31'd0, irq}, 32'd1);

    // Heartbeat: two reads five cycles apart
    req(1'b0, 16'h0018, 32'h0, hb_model);
    hb_a = rsp_rdata;
    repeat (4) @(negedge clk);
    req(1'b0, 16'h0018, 32'h0, hb_model);
    hb_b = rsp_rdata;
    check("heartbeat_delta", hb_b - hb_a, 32'd5);

    // Reset in the middle of a response
    hmc_ready = '0; gty_link_up = '0; power_good = '0; pcie_link_up = 1'b0;
    req(1'b1, 16'h0008, 32'h1111_2222, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0000;
    @(posedge clk);
    #1;
    check("pre_reset_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_reset_enables", {24'd0, hmc_enable, gty_enable}, 32'd0);
    check("mid_reset_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req(1'b0, 16'h0008, 32'h0, 32'h0);
    req(1'b0, 16'h000C, 32'h0, 32'h0);
    req(1'b0, 16'h0014, 32'h0, 32'h0);
    req(1'b0, 16'h0018, 32'h0, hb_model);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
